// File: rtl/spi_tgt_pkg.sv
// spi_tgt_pkg: opcodes, state/mode enums and constants shared by the SPI memory target.
package spi_tgt_pkg;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic MISO_IDLE = 1'b1;
  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DUMMY, WR_DATA, RD_DATA, STATUS, IGNORE} state_e;
  typedef enum logic [1:0] {M_WR, M_RD, M_FRD} mode_e;
endpackage

// File: rtl/spi_tgt_sync.sv
// spi_tgt_sync: synchronizes SPI_CLK/MOSI/SS_N into the fabric clock and derives edge pulses.
module spi_tgt_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_ss_n,
  output logic o_ss_n,
  output logic o_mosi,
  output logic o_rise,
  output logic o_fall,
  output logic o_ss_fall,
  output logic o_ss_rise
);
  logic [SYNC_STAGES:0] r_sclk, r_ss, r_fill;
  logic [SYNC_STAGES-1:0] r_mosi;
  logic w_ok;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_sclk <= '0;
      r_ss   <= '1;
      r_fill <= '0;
      r_mosi <= '0;
    end else begin
      r_sclk <= {r_sclk[SYNC_STAGES-1:0], i_sclk};
      r_ss   <= {r_ss[SYNC_STAGES-1:0], i_ss_n};
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_mosi <= {r_mosi[SYNC_STAGES-2:0], i_mosi};
    end
  // Edges are suppressed until the chain refills after reset, so a frame cut by reset is not re-entered.
  assign w_ok      = r_fill[SYNC_STAGES];
  assign o_ss_n    = r_ss[SYNC_STAGES-1];
  assign o_mosi    = r_mosi[SYNC_STAGES-1];
  assign o_rise    = w_ok & r_sclk[SYNC_STAGES-1] & ~r_sclk[SYNC_STAGES];
  assign o_fall    = w_ok & ~r_sclk[SYNC_STAGES-1] & r_sclk[SYNC_STAGES];
  assign o_ss_fall = w_ok & ~r_ss[SYNC_STAGES-1] & r_ss[SYNC_STAGES];
  assign o_ss_rise = w_ok & r_ss[SYNC_STAGES-1] & ~r_ss[SYNC_STAGES];
endmodule

// File: rtl/spi_mem_target.sv
// spi_mem_target: oversampled SPI mode-0 target decoding write/read/status commands onto a byte-memory port.
// Define SPI_TGT_FAST_READ_EN to accept fast read (0x0B) with one dummy byte.
module spi_mem_target
  import spi_tgt_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_BASE,
  input  logic              RESET,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  input  logic              SPI_SS_N,
  output logic              SPI_MISO,
  output logic              SPI_MISO_OE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  output logic              MEM_WE,
  output logic              MEM_RE,
  input  logic [7:0]        MEM_RDATA,
  output logic              CMD_ERR
);
  state_e r_state, w_next;
  mode_e r_mode;
  logic [2:0] r_bitcnt;
  logic [6:0] r_sh_in;
  logic [7:0] r_tx_buf, r_tx_sh, r_wdata, w_byte;
  logic [ADDR_W-1:0] r_addr;
  logic r_oe, r_we, r_re, r_rd_v, r_err;
  logic w_ss_n, w_mosi, w_rise_raw, w_fall_raw, w_ss_fall, w_ss_rise;
  logic w_rise, w_fall, w_done, w_fr, w_known;
  spi_tgt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk(CLK_BASE), .i_rst(RESET), .i_sclk(SPI_CLK), .i_mosi(SPI_MOSI), .i_ss_n(SPI_SS_N),
    .o_ss_n(w_ss_n), .o_mosi(w_mosi), .o_rise(w_rise_raw), .o_fall(w_fall_raw),
    .o_ss_fall(w_ss_fall), .o_ss_rise(w_ss_rise)
  );
  assign w_rise = w_rise_raw & ~w_ss_n & (r_state != IDLE);
  assign w_fall = w_fall_raw & ~w_ss_n & (r_state != IDLE);
  assign w_done = w_rise & (r_bitcnt == 3'd7);
  assign w_byte = {r_sh_in, w_mosi};
`ifdef SPI_TGT_FAST_READ_EN
  assign w_fr = (w_byte == OP_FREAD);
`else
  assign w_fr = 1'b0;
`endif
  assign w_known = (w_byte == OP_WRITE) | (w_byte == OP_READ) | w_fr;
  always_comb begin
    w_next = r_state;
    if (w_ss_rise) w_next = IDLE;
    else if (r_state == IDLE) w_next = w_ss_fall ? OPCODE : IDLE;
    else if (w_done)
      case (r_state)
        OPCODE:  w_next = w_known ? ADDR : (w_byte == OP_RDSR) ? STATUS : IGNORE;
        ADDR:    w_next = (r_mode == M_WR) ? WR_DATA : (r_mode == M_RD) ? RD_DATA : DUMMY;
        DUMMY:   w_next = RD_DATA;
        default: w_next = r_state;
      endcase
  end
  always_ff @(posedge CLK_BASE or posedge RESET)
    if (RESET) begin
      r_state  <= IDLE;
      r_mode   <= M_WR;
      r_bitcnt <= '0;
      r_sh_in  <= '0;
      r_tx_buf <= '0;
      r_tx_sh  <= '0;
      r_wdata  <= '0;
      r_addr   <= '0;
      r_oe     <= 1'b0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_rd_v   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_oe    <= ~w_ss_n;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_rd_v  <= r_re & ~w_ss_rise;
      if (r_rd_v) r_tx_buf <= MEM_RDATA;
      if (r_state == STATUS) r_tx_buf <= {7'b0, r_err};
      if (r_we) r_addr <= r_addr + ADDR_W'(1);
      if (w_ss_rise || w_ss_fall) begin
        r_bitcnt <= '0;
        r_tx_sh  <= '0;
      end else begin
        if (w_rise) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          r_sh_in  <= w_byte[6:0];
        end
        // A fall on a byte boundary starts the next outgoing byte; others shift.
        if (w_fall)
          r_tx_sh <= (r_bitcnt == 3'd0 && (r_state == RD_DATA || r_state == STATUS)) ? r_tx_buf : r_tx_sh << 1;
      end
      if (w_done) begin
        if (r_state == OPCODE) begin
          r_mode <= (w_byte == OP_WRITE) ? M_WR : w_fr ? M_FRD : M_RD;
          if (!w_known && w_byte != OP_RDSR) r_err <= 1'b1;
        end
        if (r_state == ADDR) begin
          r_addr <= ADDR_W'(w_byte);
          r_re   <= (r_mode != M_WR);
        end
        if (r_state == WR_DATA) begin
          r_wdata <= w_byte;
          r_we    <= 1'b1;
        end
        if (r_state == RD_DATA) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_re   <= 1'b1;
        end
        if (r_state == STATUS) r_err <= 1'b0;
      end
    end
  assign SPI_MISO    = r_oe & ((r_state == IGNORE) ? MISO_IDLE : r_tx_sh[7]);
  assign SPI_MISO_OE = r_oe;
  assign MEM_ADDR    = r_addr;
  assign MEM_WDATA   = r_wdata;
  assign MEM_WE      = r_we;
  assign MEM_RE      = r_re;
  assign CMD_ERR     = r_err;
endmodule

// File: tb/tb_spi_mem_target.sv
// tb_spi_mem_target: directed SPI-master stimulus against spi_mem_target with a byte RAM model.
`timescale 1ns/1ps
module tb_spi_mem_target;
  logic CLK_BASE = 1'b0, RESET = 1'b1, SPI_CLK = 1'b0, SPI_MOSI = 1'b0, SPI_SS_N = 1'b1;
  logic SPI_MISO, SPI_MISO_OE, MEM_WE, MEM_RE, CMD_ERR;
  logic [7:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [7:0] ram [256];
  logic [7:0] we_a [64], we_d [64], re_a [64];
  logic [7:0] tx_b [8], rx_b [8];
  int we_n = 0, re_n = 0, both_n = 0;
  int errs = 0, checks = 0;

  spi_mem_target dut (
    .CLK_BASE(CLK_BASE), .RESET(RESET), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_SS_N(SPI_SS_N),
    .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK_BASE = ~CLK_BASE;

  always @(posedge CLK_BASE) begin
    if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
    if (MEM_RE) MEM_RDATA <= ram[MEM_ADDR];
  end

  always @(posedge CLK_BASE) begin
    if (MEM_WE) begin
      we_a[we_n[5:0]] <= MEM_ADDR;
      we_d[we_n[5:0]] <= MEM_WDATA;
      we_n <= we_n + 1;
    end
    if (MEM_RE) begin
      re_a[re_n[5:0]] <= MEM_ADDR;
      re_n <= re_n + 1;
    end
    if (MEM_WE && MEM_RE) both_n <= both_n + 1;
  end

  // Mode 0 master: set MOSI while SPI_CLK is low, sample MISO at the rising edge.
  task automatic xfer(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      SPI_MOSI = b[7-i];
      #40;
      r = {r[6:0], SPI_MISO};
      SPI_CLK = 1'b1;
      #40;
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic frame(input int n);
    logic [7:0] r;
    SPI_SS_N = 1'b0;
    #80;
    for (int k = 0; k < n; k++) begin
      xfer(tx_b[k], 8, r);
      rx_b[k] = r;
    end
    #40;
    SPI_SS_N = 1'b1;
    #80;
  endtask

  task automatic set_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    tx_b[0] = a; tx_b[1] = b; tx_b[2] = c; tx_b[3] = d;
  endtask

  task automatic test_reset;
    #23;
    checks++; if (MEM_WE !== 1'b0) begin errs++; $display("FAIL reset_we got=%b want=0", MEM_WE); end
    checks++; if (MEM_RE !== 1'b0) begin errs++; $display("FAIL reset_re got=%b want=0", MEM_RE); end
    checks++; if (MEM_ADDR !== 8'h00) begin errs++; $display("FAIL reset_addr got=%h want=00", MEM_ADDR); end
    checks++; if (SPI_MISO_OE !== 1'b0) begin errs++; $display("FAIL reset_oe got=%b want=0", SPI_MISO_OE); end
    checks++; if (SPI_MISO !== 1'b0) begin errs++; $display("FAIL reset_miso got=%b want=0", SPI_MISO); end
    checks++; if (CMD_ERR !== 1'b0) begin errs++; $display("FAIL reset_err got=%b want=0", CMD_ERR); end
    @(negedge CLK_BASE);
    RESET = 1'b0;
    #200;
  endtask

  task automatic test_write;
    int s = we_n, r = re_n;
    set_tx(8'h02, 8'h10, 8'hAA, 8'h55);
    frame(4);
    checks++; if (we_n - s !== 2) begin errs++; $display("FAIL write_count got=%0d want=2", we_n - s); end
    checks++; if (we_a[s] !== 8'h10 || we_d[s] !== 8'hAA) begin errs++; $display("FAIL write_0 got=%h/%h want=10/aa", we_a[s], we_d[s]); end
    checks++; if (we_a[s+1] !== 8'h11 || we_d[s+1] !== 8'h55) begin errs++; $display("FAIL write_1 got=%h/%h want=11/55", we_a[s+1], we_d[s+1]); end
    checks++; if (re_n - r !== 0) begin errs++; $display("FAIL write_no_re got=%0d want=0", re_n - r); end
  endtask

  task automatic test_read;
    int r, w;
    set_tx(8'h02, 8'h20, 8'h3C, 8'hC3);
    frame(4);
    r = re_n; w = we_n;
    set_tx(8'h03, 8'h20, 8'h00, 8'h00);
    frame(4);
    checks++; if (rx_b[1] !== 8'h00) begin errs++; $display("FAIL read_addr_miso got=%h want=00", rx_b[1]); end
    checks++; if (rx_b[2] !== 8'h3C) begin errs++; $display("FAIL read_byte0 got=%h want=3c", rx_b[2]); end
    checks++; if (rx_b[3] !== 8'hC3) begin errs++; $display("FAIL read_byte1 got=%h want=c3", rx_b[3]); end
    checks++; if (re_n - r !== 3) begin errs++; $display("FAIL read_re_count got=%0d want=3", re_n - r); end
    checks++; if (re_a[r] !== 8'h20 || re_a[r+1] !== 8'h21 || re_a[r+2] !== 8'h22)
      begin errs++; $display("FAIL read_re_addr got=%h,%h,%h want=20,21,22", re_a[r], re_a[r+1], re_a[r+2]); end
    checks++; if (we_n - w !== 0) begin errs++; $display("FAIL read_no_we got=%0d want=0", we_n - w); end
  endtask

  task automatic test_wrap;
    int s = we_n;
    set_tx(8'h02, 8'hFF, 8'h11, 8'h22);
    frame(4);
    checks++; if (we_n - s !== 2) begin errs++; $display("FAIL wrap_count got=%0d want=2", we_n - s); end
    checks++; if (we_a[s] !== 8'hFF || we_d[s] !== 8'h11) begin errs++; $display("FAIL wrap_0 got=%h/%h want=ff/11", we_a[s], we_d[s]); end
    checks++; if (we_a[s+1] !== 8'h00 || we_d[s+1] !== 8'h22) begin errs++; $display("FAIL wrap_1 got=%h/%h want=00/22", we_a[s+1], we_d[s+1]); end
  endtask

  task automatic test_status;
    int s = we_n, r = re_n;
    set_tx(8'h7E, 8'h00, 8'h00, 8'h00);
    frame(2);
    checks++; if (CMD_ERR !== 1'b1) begin errs++; $display("FAIL err_set got=%b want=1", CMD_ERR); end
    checks++; if (rx_b[1] !== 8'hFF) begin errs++; $display("FAIL ignore_miso got=%h want=ff", rx_b[1]); end
    checks++; if (we_n != s || re_n != r) begin errs++; $display("FAIL ignore_strobes got=%0d/%0d want=0/0", we_n - s, re_n - r); end
    set_tx(8'h05, 8'h00, 8'h00, 8'h00);
    frame(3);
    checks++; if (rx_b[1] !== 8'h01) begin errs++; $display("FAIL status_0 got=%h want=01", rx_b[1]); end
    checks++; if (rx_b[2] !== 8'h00) begin errs++; $display("FAIL status_1 got=%h want=00", rx_b[2]); end
    checks++; if (CMD_ERR !== 1'b0) begin errs++; $display("FAIL err_clear got=%b want=0", CMD_ERR); end
  endtask

  task automatic test_abort;
    int s = we_n;
    logic [7:0] r;
    SPI_SS_N = 1'b0;
    #80;
    xfer(8'h02, 8, r);
    xfer(8'h30, 8, r);
    xfer(8'hA7, 4, r);
    #40;
    SPI_SS_N = 1'b1;
    #80;
    checks++; if (we_n - s !== 0) begin errs++; $display("FAIL abort_no_we got=%0d want=0", we_n - s); end
    set_tx(8'h02, 8'h30, 8'h5A, 8'h00);
    frame(3);
    checks++; if (we_n - s !== 1) begin errs++; $display("FAIL abort_next_count got=%0d want=1", we_n - s); end
    checks++; if (we_a[s] !== 8'h30 || we_d[s] !== 8'h5A) begin errs++; $display("FAIL abort_next got=%h/%h want=30/5a", we_a[s], we_d[s]); end
  endtask

  task automatic test_reset_mid;
    int r;
    logic [7:0] d;
    SPI_SS_N = 1'b0;
    #80;
    xfer(8'h03, 8, d);
    xfer(8'h20, 8, d);
    xfer(8'h00, 4, d);
    r = re_n;
    RESET = 1'b1;
    #1;
    checks++; if (MEM_ADDR !== 8'h00) begin errs++; $display("FAIL rmid_addr got=%h want=00", MEM_ADDR); end
    checks++; if (MEM_WDATA !== 8'h00) begin errs++; $display("FAIL rmid_wdata got=%h want=00", MEM_WDATA); end
    checks++; if (SPI_MISO_OE !== 1'b0 || SPI_MISO !== 1'b0) begin errs++; $display("FAIL rmid_miso got=%b%b want=00", SPI_MISO_OE, SPI_MISO); end
    checks++; if (MEM_RE !== 1'b0 || MEM_WE !== 1'b0 || CMD_ERR !== 1'b0) begin errs++; $display("FAIL rmid_strobes got=%b%b%b want=000", MEM_RE, MEM_WE, CMD_ERR); end
    #39;
    RESET = 1'b0;
    xfer(8'h00, 4, d);
    xfer(8'h00, 8, d);
    #40;
    SPI_SS_N = 1'b1;
    #80;
    checks++; if (re_n - r !== 0) begin errs++; $display("FAIL rmid_no_re got=%0d want=0", re_n - r); end
  endtask

  task automatic test_fast_read;
`ifdef SPI_TGT_FAST_READ_EN
    set_tx(8'h02, 8'h40, 8'hA5, 8'h00);
    frame(3);
    set_tx(8'h0B, 8'h40, 8'hFF, 8'h00);
    frame(4);
    checks++; if (rx_b[2] !== 8'h00) begin errs++; $display("FAIL fread_dummy got=%h want=00", rx_b[2]); end
    checks++; if (rx_b[3] !== 8'hA5) begin errs++; $display("FAIL fread_data got=%h want=a5", rx_b[3]); end
    checks++; if (CMD_ERR !== 1'b0) begin errs++; $display("FAIL fread_err got=%b want=0", CMD_ERR); end
`else
    set_tx(8'h0B, 8'h40, 8'hFF, 8'h00);
    frame(4);
    checks++; if (CMD_ERR !== 1'b1) begin errs++; $display("FAIL fread_unknown_err got=%b want=1", CMD_ERR); end
    checks++; if (rx_b[3] !== 8'hFF) begin errs++; $display("FAIL fread_unknown_miso got=%h want=ff", rx_b[3]); end
`endif
  endtask

  task automatic test_exclusive;
    checks++; if (both_n !== 0) begin errs++; $display("FAIL we_re_overlap got=%0d want=0", both_n); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_wrap;
    test_status;
    test_abort;
    test_reset_mid;
    test_fast_read;
    test_exclusive;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
